// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - Two-source split-transaction bus arbiter with in-order response routing
module mem_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_PRIORITY   = 1,
    parameter int STARVE_LIMIT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_cache,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_cache,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] LP_FULL  = CW'(MAX_OUTSTANDING);
    localparam logic          LP_PRIO  = (DATA_PRIORITY != 0);
    localparam logic [1:0]    LP_LIMIT = 2'(STARVE_LIMIT);

    logic                       r_lock_valid;
    logic                       r_lock_src;
    logic [MAX_OUTSTANDING-1:0] r_order;
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_count;
    logic [1:0]                 r_streak;

    logic w_grant;
    logic w_src_req;
    logic w_other_req;
    logic w_full;
    logic w_empty;
    logic w_m_req;
    logic w_accept;
    logic w_pop;
    logic w_head;

    // Source encoding everywhere: 0 = inst, 1 = data.
    always_comb begin
        w_grant = 1'b0;
        if (r_lock_valid) begin
            w_grant = r_lock_src;
        end else if (inst_req && data_req) begin
            w_grant = (r_streak == LP_LIMIT) ? ~LP_PRIO : LP_PRIO;
        end else begin
            w_grant = data_req;
        end
    end

    assign w_src_req   = w_grant ? data_req : inst_req;
    assign w_other_req = w_grant ? inst_req : data_req;
    assign w_full      = (r_count == LP_FULL);
    assign w_empty     = (r_count == '0);
    assign w_m_req     = !w_full && w_src_req;
    assign w_accept    = w_m_req && m_addr_ok;
    assign w_pop       = m_data_ok && !w_empty;
    assign w_head      = r_order[r_rd_ptr];

    // Everything is forced low during reset so nothing leaks onto either side.
    always_comb begin
        m_req        = 1'b0;
        m_cache      = 1'b0;
        m_wr         = 1'b0;
        m_wstrb      = 4'd0;
        m_size       = 3'd0;
        m_addr       = 32'd0;
        m_wdata      = 32'd0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        if (!reset) begin
            m_req        = w_m_req;
            m_cache      = w_grant ? data_cache : inst_cache;
            m_wr         = w_grant && data_wr;
            m_wstrb      = w_grant ? data_wstrb : 4'd0;
            m_size       = w_grant ? data_size : 3'd2;
            m_addr       = w_grant ? data_addr : inst_addr;
            m_wdata      = w_grant ? data_wdata : 32'd0;
            inst_addr_ok = w_accept && !w_grant;
            data_addr_ok = w_accept && w_grant;
            inst_data_ok = w_pop && !w_head;
            data_data_ok = w_pop && w_head;
            inst_rdata   = m_rdata;
            data_rdata   = m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_valid <= 1'b0;
            r_lock_src   <= 1'b0;
            r_order      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_streak     <= '0;
        end else begin
            // A request that the bus refuses keeps the grant until it is taken.
            if (w_accept) begin
                r_lock_valid <= 1'b0;
            end else if (w_m_req) begin
                r_lock_valid <= 1'b1;
                r_lock_src   <= w_grant;
            end

            if (w_accept) begin
                r_order[r_wr_ptr] <= w_grant;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                if (w_grant == LP_PRIO && w_other_req) begin
                    if (r_streak != LP_LIMIT) begin
                        r_streak <= r_streak + 1'b1;
                    end
                end else begin
                    r_streak <= '0;
                end
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - Self-checking bench for mem_bus_arbiter with a queue-based reference model
module tb_mem_bus_arbiter;
    localparam int MAXO  = 4;
    localparam bit PRIO  = 1'b1;
    localparam int LIMIT = 2;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_cache, data_wr;
    logic [3:0]  data_wstrb;
    logic [2:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_cache, m_wr;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int checks   = 0;
    int failures = 0;

    mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .DATA_PRIORITY(1), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .m_req(m_req), .m_cache(m_cache), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding sources in a queue, a pending-grant holder and a win streak.
    bit mq[$];
    int mlock   = -1;
    int mstreak = 0;

    always @(negedge clk) begin : model
        bit g, full, ereq, acc, pop, oth;
        if (reset) begin
            chk("rst_ctrl", {31'd0, |{m_req, m_cache, m_wr, m_wstrb, m_size, inst_addr_ok,
                data_addr_ok, inst_data_ok, data_data_ok}}, 32'd0);
            chk("rst_data", m_addr | m_wdata | inst_rdata | data_rdata, 32'd0);
            mq.delete();
            mlock   = -1;
            mstreak = 0;
        end else begin
            full = (mq.size() == MAXO);
            if (mlock >= 0)                  g = mlock[0];
            else if (inst_req && data_req)   g = (mstreak == LIMIT) ? !PRIO : PRIO;
            else                             g = data_req;
            oth  = g ? inst_req : data_req;
            ereq = !full && (g ? data_req : inst_req);
            acc  = ereq && m_addr_ok;
            pop  = m_data_ok && (mq.size() > 0);

            chk("m_req", m_req, ereq);
            chk("inst_addr_ok", inst_addr_ok, acc && !g);
            chk("data_addr_ok", data_addr_ok, acc && g);
            chk("inst_data_ok", inst_data_ok, pop && !mq[0]);
            chk("data_data_ok", data_data_ok, pop && mq[0]);
            chk("inst_rdata", inst_rdata, m_rdata);
            chk("data_rdata", data_rdata, m_rdata);
            if (ereq) begin
                chk("m_addr", m_addr, g ? data_addr : inst_addr);
                chk("m_wdata", m_wdata, g ? data_wdata : 32'd0);
                chk("m_attr", {23'd0, m_cache, m_wr, m_wstrb, m_size},
                    {23'd0, (g ? data_cache : inst_cache), (g & data_wr),
                     (g ? data_wstrb : 4'd0), (g ? data_size : 3'd2)});
            end

            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(g);
                if (g == PRIO && oth) mstreak = (mstreak < LIMIT) ? mstreak + 1 : LIMIT;
                else                  mstreak = 0;
                mlock = -1;
            end else if (ereq) begin
                mlock = g;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req  = 1'b0;
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
    endtask

    initial begin : stim
        logic [5:0] exp_d;
        logic [3:0] pat4;
        logic [9:0] pat10;
        bit         seq[13];

        reset      = 1'b1;
        inst_cache = 1'b0;
        inst_addr  = 32'h0000_0100;
        data_cache = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_size  = 3'd1;
        data_addr  = 32'h0000_0200;
        data_wdata = 32'hCAFE_F00D;
        m_rdata    = 32'h1234_5678;
        idle();
        cyc();
        cyc();
        reset = 1'b0;

        // Single data access, accepted in the request cycle, answered two cycles later.
        data_req = 1'b1; data_addr = 32'h0000_1000; m_addr_ok = 1'b1;
        #2;
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'h0000_1000);
        chk("t1_data_addr_ok", data_addr_ok, 1);
        cyc();
        idle();
        cyc();
        m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        #2;
        chk("t1_data_data_ok", data_data_ok, 1);
        chk("t1_inst_data_ok", inst_data_ok, 0);
        chk("t1_data_rdata", data_rdata, 32'hDEAD_BEEF);
        cyc();
        idle();

        // Refused request keeps the grant, even when the holder drops req.
        inst_req = 1'b1; inst_addr = 32'h0000_2000;
        data_req = 1'b1; data_addr = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t2_lock_addr", m_addr, 32'h0000_3000);
            chk("t2_no_ok", {inst_addr_ok, data_addr_ok}, 0);
            cyc();
        end
        data_req = 1'b0;
        #2;
        chk("t2_violation_m_req", m_req, 0);
        chk("t2_violation_inst_ok", inst_addr_ok, 0);
        cyc();
        data_req = 1'b1; m_addr_ok = 1'b1;
        #2;
        chk("t2_data_taken", data_addr_ok, 1);
        cyc();
        data_req = 1'b0;
        #2;
        chk("t2_inst_taken", inst_addr_ok, 1);
        cyc();
        idle();
        m_data_ok = 1'b1;
        #2;
        chk("t2_resp0_data", data_data_ok, 1);
        cyc();
        #2;
        chk("t2_resp1_inst", inst_data_ok, 1);
        cyc();
        idle();

        // Starvation guard: D,D,I,D,D,I under continuous contention.
        exp_d = 6'b011011;
        for (int i = 0; i < 6; i++) begin
            inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
            inst_addr = 32'h0000_5000 + i; data_addr = 32'h0000_4000 + i;
            #2;
            chk("t3_grant_data", data_addr_ok, exp_d[i]);
            chk("t3_grant_inst", inst_addr_ok, !exp_d[i]);
            cyc();
        end
        idle();
        m_data_ok = 1'b1;
        cyc();
        idle();

        // Fill to capacity, block, then drain with in-order routing.
        pat4 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            inst_req = !pat4[i]; data_req = pat4[i]; m_addr_ok = 1'b1;
            cyc();
        end
        inst_req = 1'b0; data_req = 1'b1; m_addr_ok = 1'b1;
        #2;
        chk("t4_full_m_req", m_req, 0);
        chk("t4_full_no_ok", data_addr_ok, 0);
        cyc();
        m_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_data_ok = 1'b1;
            #2;
            chk("t4_route_inst", inst_data_ok, !pat4[i]);
            chk("t4_route_data", data_data_ok, pat4[i]);
            chk("t4_m_req_reassert", m_req, (i == 0) ? 0 : 1);
            cyc();
        end
        m_data_ok = 1'b0; m_addr_ok = 1'b1;
        #2;
        chk("t4_after_drain_ok", data_addr_ok, 1);
        cyc();
        idle();
        m_data_ok = 1'b1;
        cyc();
        idle();

        // Steady state at count 3 with simultaneous accept and response; pointers wrap.
        seq[0] = 0; seq[1] = 1; seq[2] = 0;
        for (int i = 0; i < 3; i++) begin
            inst_req = !seq[i]; data_req = seq[i]; m_addr_ok = 1'b1;
            cyc();
        end
        pat10 = 10'b11_0100_1011;
        for (int i = 0; i < 10; i++) seq[i + 3] = pat10[i];
        for (int i = 0; i < 10; i++) begin
            inst_req = !pat10[i]; data_req = pat10[i]; m_addr_ok = 1'b1; m_data_ok = 1'b1;
            data_wdata = 32'hA500_0000 + i;
            #2;
            chk("t5_accept", {inst_addr_ok, data_addr_ok}, {!pat10[i], pat10[i]});
            chk("t5_route_data", data_data_ok, seq[i]);
            chk("t5_route_inst", inst_data_ok, !seq[i]);
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            m_data_ok = 1'b1;
            #2;
            chk("t5_drain_inst", inst_data_ok, (i < 3) ? !seq[10 + i] : 0);
            chk("t5_drain_data", data_data_ok, (i < 3) ? seq[10 + i] : 0);
            cyc();
        end
        idle();

        // Reset while two requests are outstanding and a grant is held.
        inst_req = 1'b1; m_addr_ok = 1'b1;
        cyc();
        inst_req = 1'b0; data_req = 1'b1;
        cyc();
        m_addr_ok = 1'b0;
        cyc();
        reset = 1'b1;
        #2;
        chk("t6_rst_m_req", m_req, 0);
        cyc();
        reset = 1'b0;
        idle();
        #2;
        chk("t6_post_m_req", m_req, 0);
        cyc();
        m_data_ok = 1'b1;
        #2;
        chk("t6_stray_ok", {inst_data_ok, data_data_ok}, 0);
        cyc();
        m_data_ok = 1'b0; inst_req = 1'b1; m_addr_ok = 1'b1;
        #2;
        chk("t6_lock_cleared", inst_addr_ok, 1);
        cyc();
        idle();
        m_data_ok = 1'b1;
        cyc();
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Merges the core's instruction-fetch port and data port onto one shared memory bus.
- All three ports use the same req/addr_ok/data_ok split-transaction handshake.
- Tracks up to MAX_OUTSTANDING accepted requests and routes each in-order response back to its originator.
- Sits between the CPU core and the cache/AXI bridge.

Parameters:
- MAX_OUTSTANDING, 4, depth of the order FIFO; maximum accepted-but-unanswered requests (power of 2, >=2).
- DATA_PRIORITY, 1, 1 = data wins simultaneous requests, 0 = inst wins.
- STARVE_LIMIT, 2, consecutive wins by the priority source while the other source waits, after which the other source is forced to win once (1..3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- inst_req  in  1  instruction request
- inst_cache  in  1  cacheable attribute
- inst_addr  in  32  physical address
- inst_addr_ok  out  1  inst request accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst read data
- data_req  in  1  data request
- data_cache  in  1  cacheable attribute
- data_wr  in  1  1 = write
- data_wstrb  in  4  byte strobes
- data_size  in  3  access size
- data_addr  in  32  physical address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- m_req  out  1  bus request
- m_cache, m_wr  out  1 each  forwarded attributes
- m_wstrb  out  4  forwarded strobes
- m_size  out  3  forwarded size
- m_addr, m_wdata  out  32 each  forwarded address and data
- m_addr_ok  in  1  bus accepted request
- m_data_ok  in  1  bus response valid; responses arrive in acceptance order
- m_rdata  in  32  bus read data

Behaviour:
- Reset: lock_valid=0, FIFO empty (count=0, rd/wr ptr=0), streak=0. All outputs 0 in the reset cycle.
- Inst request forwarding: m_wr=0, m_wstrb=0, m_size=3'd2, m_wdata=0.
- Grant, registered lock state machine:
  - UNLOCKED: grant is computed combinationally.
    - Only one source requesting: that source wins.
    - Both requesting: the priority source wins unless streak==STARVE_LIMIT, in which case the other source wins.
  - LOCKED: grant equals lock_src.
- m_req = !full && (LOCKED ? req of lock_src : inst_req||data_req). m_* payload is muxed from the granted source.
- Transition UNLOCKED->LOCKED when m_req && !m_addr_ok; record lock_src = grant.
- Transition LOCKED->UNLOCKED on m_req && m_addr_ok.
- Requesters hold req and payload until their addr_ok. Deassertion while locked is a protocol violation: m_req drops and the lock holds.
- Acceptance: inst_addr_ok = m_req && m_addr_ok && grant==inst; data_addr_ok likewise. Zero-cycle combinational path.
- Order FIFO, 1-bit entries (0=inst, 1=data):
  - Push grant on acceptance; pop on m_data_ok.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - Count width clog2(MAX_OUTSTANDING+1).
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==MAX_OUTSTANDING): m_req=0, no addr_ok. A pop in the same cycle does not unblock; m_req asserts the following cycle.
- Response routing:
  - inst_data_ok = m_data_ok && !empty && head==0; data_data_ok = m_data_ok && !empty && head==1.
  - inst_rdata = data_rdata = m_rdata, unqualified.
  - m_data_ok while empty is ignored: no pop, no ok pulse.
- Streak update on each acceptance:
  - Counts consecutive acceptances of the priority source made while the other source's req was high; saturates at STARVE_LIMIT.
  - Resets to 0 on any acceptance of the non-priority source, or any acceptance made while the other source was idle.
- Reset mid-transaction: lock and FIFO are cleared immediately. Responses still in flight on the bus after reset are dropped via the empty rule. The bus side must be reset by the same signal.

Test Plan:
- Reset, then data_req alone with data_addr=0x1000, m_addr_ok=1 same cycle -> m_req=1, m_addr=0x1000, data_addr_ok=1 that cycle; m_data_ok with m_rdata=0xDEADBEEF 2 cycles later -> data_data_ok=1, inst_data_ok=0.
- inst_req and data_req together, m_addr_ok held 0 for 3 cycles, then data_req dropped and inst_req kept -> m_addr stays data_addr for all 3 cycles (lock holds).
- DATA_PRIORITY=1, STARVE_LIMIT=2, both requesting every cycle, m_addr_ok=1 -> grant order D,D,I,D,D,I.
- 4 accepted requests (I,D,D,I), no m_data_ok -> 5th request gets m_req=0. Then 4 m_data_ok pulses -> ok pulses routed inst,data,data,inst; m_req reasserts the cycle after the first pop.
- Acceptance and m_data_ok in the same cycle at count=3 -> count stays 3, head routing correct, wrapped pointers verified over 10 transactions.
- Assert reset with count=2 and lock active -> next cycle m_req=0, count=0; a following stray m_data_ok produces no inst/data_data_ok.
